// File: rtl/sync_pkg.sv
// Shared definitions for the synchronizer-path word checker: FSM state encoding,
// readout select codes, counter widths and the status-byte packing helper.
package sync_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    STALLED = 2'd2
  } state_e;

  localparam logic [1:0] SEL_LAST   = 2'd0;
  localparam logic [1:0] SEL_OK     = 2'd1;
  localparam logic [1:0] SEL_ERR    = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  localparam int unsigned OK_CNT_W     = 16;
  localparam int unsigned ERR_CNT_W    = 8;
  localparam int unsigned GLITCH_CNT_W = 4;
  localparam int unsigned IDLE_CNT_W   = 16;
  localparam int unsigned RD_W         = 8;

  // Status readout layout: {glitch_cnt, 0, err_flag, stall, locked}
  function automatic logic [RD_W-1:0] status_byte(input logic [GLITCH_CNT_W-1:0] glitch,
                                                  input logic err, input logic stl,
                                                  input logic lck);
    return {glitch, 1'b0, err, stl, lck};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and enable.
// Ports: clk/rst (sync, active-high), en_i freezes the count, clr_i clears
// (priority over inc_i), inc_i increments until all-ones. cnt_o is the
// registered count; nxt_c_o is the combinational value it loads next.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_c_o
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  // Next count: clear wins, otherwise increment unless already saturated
  always_comb begin
    nxt_c_o = cnt_o;
    if (clr_i) begin
      nxt_c_o = '0;
    end else if (inc_i && (cnt_o != MAX)) begin
      nxt_c_o = cnt_o + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= nxt_c_o;
    end
  end

endmodule

// File: rtl/cdc_word_checker.sv
// Destination-domain checker for a synchronizer path: verifies that the
// qualified words form an incrementing (mod 2^N) sequence, counts good words,
// sequence errors, unqualified data changes and stalls.
// Ports: clk, rst (sync active-high), ena (freeze when low), data_in/valid
// (synchronized word + one-cycle qualifier), sel (readout select);
// locked, stall, err_flag (sticky), rd_out (registered readout mux).
module cdc_word_checker
  import sync_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [N-1:0]    data_in,
  input  logic            valid,
  input  logic [1:0]      sel,
  output logic            locked,
  output logic            stall,
  output logic            err_flag,
  output logic [RD_W-1:0] rd_out
);

  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_W = IDLE_CNT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [N-1:0]        last_word_q, last_word_d;
  logic [N-1:0]        exp_word_q, exp_word_d;
  logic [N-1:0]        prev_data_q;
  logic                err_flag_d;
  logic [RD_W-1:0]     rd_d;

  logic                word_ok;
  logic                data_new;
  logic                ok_inc, err_inc, glitch_inc, idle_inc, idle_clr;

  logic [OK_CNT_W-1:0]     ok_cnt_q, ok_cnt_nxt;
  logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_nxt;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q, glitch_cnt_nxt;
  logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_nxt;

  assign word_ok  = (data_in == exp_word_q);
  // A glitch is counted only on the first cycle a differing value appears
  assign data_new = (data_in != last_word_q) && (data_in != prev_data_q);

  // Next-state, compare and counter-control logic
  always_comb begin
    state_d     = state_q;
    last_word_d = last_word_q;
    exp_word_d  = exp_word_q;
    err_flag_d  = err_flag;
    ok_inc      = 1'b0;
    err_inc     = 1'b0;
    glitch_inc  = 1'b0;
    idle_inc    = 1'b0;
    idle_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          state_d     = TRACK;
          last_word_d = data_in;
          exp_word_d  = data_in + N'(1);
          idle_clr    = 1'b1;
        end
      end
      TRACK, STALLED: begin
        if (valid) begin
          state_d     = TRACK;
          last_word_d = data_in;
          exp_word_d  = data_in + N'(1);
          idle_clr    = 1'b1;
          if (word_ok) begin
            ok_inc = 1'b1;
          end else begin
            err_inc    = 1'b1;
            err_flag_d = 1'b1;
          end
        end else begin
          glitch_inc = data_new;
          if (state_q == TRACK) begin
            idle_inc = 1'b1;
            if (idle_cnt_q >= TIMEOUT_W) begin
              state_d = STALLED;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Readout mux over next-cycle values so rd_out tracks the other outputs
  always_comb begin
    rd_d = '0;
    case (sel)
      SEL_LAST: rd_d = RD_W'(last_word_d);
      SEL_OK:   rd_d = ok_cnt_nxt[RD_W-1:0];
      SEL_ERR:  rd_d = RD_W'(err_cnt_nxt);
      default:  rd_d = status_byte(glitch_cnt_nxt, err_flag_d,
                                   state_d == STALLED, state_d != IDLE);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_word_q <= '0;
      exp_word_q  <= '0;
      prev_data_q <= '0;
      err_flag    <= 1'b0;
      locked      <= 1'b0;
      stall       <= 1'b0;
      rd_out      <= '0;
    end else if (ena) begin
      state_q     <= state_d;
      last_word_q <= last_word_d;
      exp_word_q  <= exp_word_d;
      prev_data_q <= data_in;
      err_flag    <= err_flag_d;
      locked      <= (state_d != IDLE);
      stall       <= (state_d == STALLED);
      rd_out      <= rd_d;
    end
  end

  sat_counter #(.W(OK_CNT_W)) u_ok_cnt (
    .clk(clk), .rst(rst), .en_i(ena), .clr_i(1'b0), .inc_i(ok_inc),
    .cnt_o(ok_cnt_q), .nxt_c_o(ok_cnt_nxt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .en_i(ena), .clr_i(1'b0), .inc_i(err_inc),
    .cnt_o(err_cnt_q), .nxt_c_o(err_cnt_nxt)
  );

  sat_counter #(.W(GLITCH_CNT_W)) u_glitch_cnt (
    .clk(clk), .rst(rst), .en_i(ena), .clr_i(1'b0), .inc_i(glitch_inc),
    .cnt_o(glitch_cnt_q), .nxt_c_o(glitch_cnt_nxt)
  );

  sat_counter #(.W(IDLE_CNT_W)) u_idle_cnt (
    .clk(clk), .rst(rst), .en_i(ena), .clr_i(idle_clr), .inc_i(idle_inc),
    .cnt_o(idle_cnt_q), .nxt_c_o(idle_cnt_nxt)
  );

  // Counter bits that only feed saturation internally, never the readout
  logic unused_cnt_bits;
  assign unused_cnt_bits = ^{ok_cnt_q, ok_cnt_nxt[OK_CNT_W-1:RD_W], err_cnt_q,
                             glitch_cnt_q, idle_cnt_nxt};

endmodule

// File: doc/cdc_word_checker.md
# cdc_word_checker

Single-clock checker that sits directly downstream of the synchronizer stages, in the destination (`clk_2`) domain. It consumes the word/valid pair produced by a synchronizer path and verifies that the source sent an incrementing sequence. It counts good words, sequence errors, unqualified data changes and stalls, and exposes the results through an 8-bit readout mux for the output pins.

## Interface
- `N`, 8: data word width.
- `TIMEOUT`, 255: idle cycles after the last valid before `stall` asserts; legal range 1 to 65535.
- `clk` in 1: destination-domain clock (driven from the `clk_2` net).
- `rst` in 1: reset, synchronous, active-high.
- `ena` in 1: checker enable; when low, all state holds and inputs are ignored.
- `data_in` in N: synchronized data word.
- `valid` in 1: one-cycle qualifier for `data_in` (e.g. toggle-sync `pulse_out`).
- `sel` in 2: readout select.
- `locked` out 1: first word seen; sequence is being tracked.
- `stall` out 1: locked and no valid for `TIMEOUT` cycles.
- `err_flag` out 1: sticky; set on the first sequence error.
- `rd_out` out 8: readout.
  - 0 = `last_word[7:0]`
  - 1 = `ok_cnt[7:0]`
  - 2 = `err_cnt`
  - 3 = `{glitch_cnt[3:0], 1'b0, err_flag, stall, locked}`

## Operation
- FSM states:
  - IDLE: reset state; waiting for the first valid.
  - TRACK: comparing each valid word against the expected value.
  - STALLED: timeout reached while locked.
- IDLE + valid: load `last_word = data_in` and `expect = data_in + 1`, then go to TRACK. `ok_cnt` is not incremented for this seed word.
- TRACK + valid:
  - If `data_in == expect`, increment `ok_cnt`.
  - Otherwise increment `err_cnt` and set `err_flag`.
  - In both cases load `last_word = data_in`, set `expect = data_in + 1` (resync to the received word), and clear `idle_cnt`.
- Arithmetic: `expect` wraps modulo 2^N, so `8'hFF` followed by `8'h00` is good.
- Counters: `ok_cnt` is 16 bits, `err_cnt` is 8 bits, `glitch_cnt` is 4 bits. All saturate and never wrap.
- Glitch detection: in TRACK or STALLED, if valid is low and `data_in != last_word`, increment `glitch_cnt`.
  - Only the first cycle of each differing value counts. This requires a registered copy of the previous-cycle `data_in`.
- Stall: in TRACK with valid low, `idle_cnt` increments. When it reaches `TIMEOUT`, go to STALLED.
- STALLED + valid: run the normal TRACK compare on that word and return to TRACK.
- `locked` = state is not IDLE. `stall` = state is STALLED.
- `ena` low freezes every register, including `idle_cnt`.
- `rst` is synchronous and takes priority over `ena` and `valid`.

## Timing
- All outputs are registered. The effect of a valid in cycle t is visible in cycle t+1.
- `rd_out` is a registered mux, so a `sel` change shows on `rd_out` one cycle later.
- `stall` asserts on the cycle after `idle_cnt` reaches `TIMEOUT`, i.e. `TIMEOUT+1` cycles after the last valid. It deasserts the cycle after the next valid.
- Valid on consecutive cycles: every cycle is processed; there is no back-pressure.
- Reset, including mid-operation: on the clock after `rst` is sampled high, everything clears.
  - State = IDLE; all counters, `last_word`, `expect`, `idle_cnt`: 0.
  - Outputs: `err_flag`, `locked`, `stall`: 0; `rd_out`: 0.
  - A valid in the same cycle as `rst` is dropped.

## Structure
- Shared package `sync_pkg`:
  - FSM state enum: IDLE=0, TRACK=1, STALLED=2.
  - Readout select constants.
  - Counter widths.
- Sub-module `sat_counter` (parameterized width; inc, clr, en) is used for `ok_cnt`, `err_cnt`, `glitch_cnt` and `idle_cnt`. `idle_cnt` is 16 bits.
- The top-level contains the FSM, the compare logic and the readout mux.

## Test plan
- In-order sequence: after reset, send valid with `8'h10`, `8'h11`, `8'h12`. Required: `locked`=1, `ok_cnt`=2, `err_cnt`=0, `rd_out` at `sel=0` is `8'h12`.
- Wrap and error: send `8'hFE`, `8'hFF`, `8'h00`, `8'h05`, `8'h06`. Required: `ok_cnt`=3, `err_cnt`=1, `err_flag`=1 and stays set after the good `8'h06`.
- Glitch: locked with `last_word=8'h20`. With valid low, drive `data_in` to `8'h21` for 3 cycles, then to `8'h20`. Required: `glitch_cnt`=1; `ok_cnt` and `err_cnt` unchanged.
- Stall: `TIMEOUT`=4, one valid, then idle. Required: `stall` rises exactly 5 cycles after the valid and clears the cycle after the next valid. That word is counted good if it equals `expect`.
- Saturation and reset: drive 300 bad words. Required: `err_cnt`=255. Then assert `rst` for 1 cycle together with a valid. Required: all outputs are 0, state is IDLE, and the valid is ignored.
- Enable freeze: `ena`=0 while sending valids. Required: no counter or state change and no stall progression; behaviour resumes when `ena`=1.
